safe_sequencer: RTL and testbench

Combination-entry controller for the safe: consumes the direction-change and dial-value outputs of the dial front end (decoder plus digit counter) and sequences a three-digit combination entry. It compares the entry against a stored code, drives the lock state, counts failed attempts with a timed lockout, and allows re-programming the code while open. It sits between the dial datapath and the lock actuator and display logic.

---
 rtl/safe_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_safe_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/safe_sequencer.sv
// safe_sequencer: combination-entry controller for the safe.
// Collects three dial digits (the third one arrives with open_btn), checks them
// against the stored code, and drives the lock state. It also counts failed
// attempts with a timed lockout and lets the code be re-programmed while open.
module safe_sequencer #(
   parameter int          NUM_DIGITS     = 3,
   parameter logic [11:0] DEFAULT_CODE   = 12'h123,
   parameter int          MAX_FAILS      = 3,
   parameter int          LOCKOUT_CYCLES = 1000,
   parameter int          TIMEOUT_CYCLES = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dirch,
   input  logic [3:0] dial,
   input  logic       open_btn,
   input  logic       lock_btn,
   input  logic       set_btn,
   output logic       unlocked,
   output logic       locked_out,
   output logic       err,
   output logic       cnt_rst,
   output logic [1:0] digits_entered
);

   // Index of the last digit; the final digit is taken from dial together with open_btn
   localparam logic [1:0] LAST_IDX = 2'(NUM_DIGITS - 1);
   localparam logic [2:0] MAX_F    = 3'(MAX_FAILS);

   // Counter widths sized so that (cycles - 1) always fits
   localparam int LKW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
   localparam int TOW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [LKW-1:0] LK_LAST = LKW'(LOCKOUT_CYCLES - 1);
   localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_LOCKED,
      S_ENTRY,
      S_CHECK,
      S_OPEN,
      S_SET,
      S_LOCKOUT
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [11:0]    code;
   logic [3:0]     entry0;
   logic [3:0]     entry1;
   logic [3:0]     entry2;
   logic [3:0]     new0;
   logic [3:0]     new1;
   logic [1:0]     idx;
   logic           bad;
   logic [2:0]     fails;
   logic [2:0]     fails_inc;
   logic           match;
   logic [LKW-1:0] lock_cnt;
   logic [TOW-1:0] idle_cnt;
   logic           idle_done;
   logic           lock_done;

   // An overrun entry can never match, even if the buffered digits equal the code
   assign match     = ({entry0, entry1, entry2} == code) && !bad;
   assign fails_inc = fails + 3'd1;
   assign idle_done = (idle_cnt == TO_LAST);
   assign lock_done = (lock_cnt == '0);

   // State register; reset returns to LOCKED on the same edge
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_LOCKED;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; lock_btn and open_btn take priority where they collide
   always_comb begin
      state_nxt = state;
      case (state)
         S_LOCKED: begin
            if (dirch) begin
               state_nxt = S_ENTRY;
            end
         end
         S_ENTRY: begin
            if (open_btn) begin
               state_nxt = S_CHECK;
            end else if (dirch) begin
               if (idx == LAST_IDX) begin
                  state_nxt = S_CHECK;
               end
            end else if (idle_done) begin
               state_nxt = S_LOCKED;
            end
         end
         S_CHECK: begin
            if (match) begin
               state_nxt = S_OPEN;
            end else if (fails_inc == MAX_F) begin
               state_nxt = S_LOCKOUT;
            end else begin
               state_nxt = S_LOCKED;
            end
         end
         S_OPEN: begin
            if (lock_btn) begin
               state_nxt = S_LOCKED;
            end else if (set_btn) begin
               state_nxt = S_SET;
            end
         end
         S_SET: begin
            if (lock_btn) begin
               state_nxt = S_LOCKED;
            end else if (open_btn && (idx == LAST_IDX)) begin
               state_nxt = S_OPEN;
            end
         end
         S_LOCKOUT: begin
            if (lock_done) begin
               state_nxt = S_LOCKED;
            end
         end
         default: begin
            state_nxt = S_LOCKED;
         end
      endcase
   end

   // Status outputs decoded straight from the registered state and digit index
   always_comb begin
      unlocked       = (state == S_OPEN) || (state == S_SET);
      locked_out     = (state == S_LOCKOUT);
      digits_entered = idx;
   end

   // Digit buffers, stored code, fail count, timers and the registered pulses
   always_ff @(posedge clk) begin
      if (!rst) begin
         code     <= DEFAULT_CODE;
         entry0   <= '0;
         entry1   <= '0;
         entry2   <= '0;
         new0     <= '0;
         new1     <= '0;
         idx      <= '0;
         bad      <= 1'b0;
         fails    <= '0;
         lock_cnt <= '0;
         idle_cnt <= '0;
         err      <= 1'b0;
         cnt_rst  <= 1'b0;
      end else begin
         err     <= 1'b0;
         cnt_rst <= 1'b0;
         case (state)
            S_LOCKED: begin
               if (dirch) begin
                  entry0   <= dial;
                  idx      <= 2'd1;
                  idle_cnt <= '0;
               end
            end
            S_ENTRY: begin
               if (open_btn) begin
                  entry2 <= dial;
               end else if (dirch) begin
                  idle_cnt <= '0;
                  if (idx == LAST_IDX) begin
                     bad <= 1'b1;
                  end else begin
                     entry1 <= dial;
                     idx    <= idx + 2'd1;
                  end
               end else if (idle_done) begin
                  idx      <= '0;
                  idle_cnt <= '0;
                  cnt_rst  <= 1'b1;
               end else begin
                  idle_cnt <= idle_cnt + TOW'(1);
               end
            end
            S_CHECK: begin
               idx     <= '0;
               bad     <= 1'b0;
               cnt_rst <= 1'b1;
               if (match) begin
                  fails <= '0;
               end else begin
                  err <= 1'b1;
                  if (fails_inc == MAX_F) begin
                     fails    <= '0;
                     lock_cnt <= LK_LAST;
                  end else begin
                     fails <= fails_inc;
                  end
               end
            end
            S_OPEN: begin
               if (!lock_btn && set_btn) begin
                  idx     <= '0;
                  cnt_rst <= 1'b1;
               end
            end
            S_SET: begin
               if (lock_btn) begin
                  idx <= '0;
               end else if (open_btn && (idx == LAST_IDX)) begin
                  code <= {new0, new1, dial};
                  idx  <= '0;
               end else if (dirch && (idx != LAST_IDX)) begin
                  if (idx == 2'd0) begin
                     new0 <= dial;
                  end else begin
                     new1 <= dial;
                  end
                  idx <= idx + 2'd1;
               end
            end
            S_LOCKOUT: begin
               if (!lock_done) begin
                  lock_cnt <= lock_cnt - LKW'(1);
               end
            end
            default: begin
               idx <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_safe_sequencer.sv
// tb_safe_sequencer: directed scenarios plus randomized traffic for safe_sequencer.
// A behavioural model tracks the lock's mode, digits, code and timers and
// predicts every output after every clock edge.
module tb_safe_sequencer;

   localparam int TIMEOUT = 5000;
   localparam int LOCKOUT = 1000;
   localparam int MAXF    = 3;

   localparam int M_LOCKED  = 0;
   localparam int M_ENTRY   = 1;
   localparam int M_CHECK   = 2;
   localparam int M_OPEN    = 3;
   localparam int M_SET     = 4;
   localparam int M_LOCKOUT = 5;

   logic       clk;
   logic       rst;
   logic       dirch;
   logic [3:0] dial;
   logic       open_btn;
   logic       lock_btn;
   logic       set_btn;
   logic       unlocked;
   logic       locked_out;
   logic       err;
   logic       cnt_rst;
   logic [1:0] digits_entered;

   int testsRun = 0;
   int failures = 0;

   // Model state
   int          mMode;
   logic [3:0]  mEntry [3];
   logic [3:0]  mNew [2];
   int          mIdx;
   bit          mBad;
   logic [11:0] mCode;
   int          mFails;
   int          mIdle;
   int          mLockLeft;
   bit          mErr;
   bit          mCnt;

   safe_sequencer #(
      .NUM_DIGITS(3),
      .DEFAULT_CODE(12'h123),
      .MAX_FAILS(MAXF),
      .LOCKOUT_CYCLES(LOCKOUT),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .dirch(dirch),
      .dial(dial),
      .open_btn(open_btn),
      .lock_btn(lock_btn),
      .set_btn(set_btn),
      .unlocked(unlocked),
      .locked_out(locked_out),
      .err(err),
      .cnt_rst(cnt_rst),
      .digits_entered(digits_entered)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      mMode     = M_LOCKED;
      mEntry[0] = 4'd0;
      mEntry[1] = 4'd0;
      mEntry[2] = 4'd0;
      mNew[0]   = 4'd0;
      mNew[1]   = 4'd0;
      mIdx      = 0;
      mBad      = 1'b0;
      mCode     = 12'h123;
      mFails    = 0;
      mIdle     = 0;
      mLockLeft = 0;
      mErr      = 1'b0;
      mCnt      = 1'b0;
   endtask

   // One clock edge of the lock's behaviour, from the inputs sampled on that edge
   task automatic modelStep();
      if (!rst) begin
         modelReset();
         return;
      end
      mErr = 1'b0;
      mCnt = 1'b0;
      case (mMode)
         M_LOCKED: begin
            if (dirch) begin
               mEntry[0] = dial;
               mIdx      = 1;
               mIdle     = 0;
               mMode     = M_ENTRY;
            end
         end
         M_ENTRY: begin
            if (open_btn) begin
               mEntry[2] = dial;
               mMode     = M_CHECK;
            end else if (dirch) begin
               mIdle = 0;
               if (mIdx == 2) begin
                  mBad  = 1'b1;
                  mMode = M_CHECK;
               end else begin
                  mEntry[mIdx] = dial;
                  mIdx++;
               end
            end else begin
               mIdle++;
               if (mIdle == TIMEOUT) begin
                  mMode = M_LOCKED;
                  mIdx  = 0;
                  mCnt  = 1'b1;
               end
            end
         end
         M_CHECK: begin
            mCnt = 1'b1;
            if ({mEntry[0], mEntry[1], mEntry[2]} == mCode && !mBad) begin
               mMode  = M_OPEN;
               mFails = 0;
            end else begin
               mErr = 1'b1;
               mFails++;
               if (mFails == MAXF) begin
                  mFails    = 0;
                  mLockLeft = LOCKOUT;
                  mMode     = M_LOCKOUT;
               end else begin
                  mMode = M_LOCKED;
               end
            end
            mIdx = 0;
            mBad = 1'b0;
         end
         M_OPEN: begin
            if (lock_btn) begin
               mMode = M_LOCKED;
            end else if (set_btn) begin
               mMode = M_SET;
               mIdx  = 0;
               mCnt  = 1'b1;
            end
         end
         M_SET: begin
            if (lock_btn) begin
               mMode = M_LOCKED;
               mIdx  = 0;
            end else if (open_btn && mIdx == 2) begin
               mCode = {mNew[0], mNew[1], dial};
               mMode = M_OPEN;
               mIdx  = 0;
            end else if (dirch && mIdx < 2) begin
               mNew[mIdx] = dial;
               mIdx++;
            end
         end
         M_LOCKOUT: begin
            mLockLeft--;
            if (mLockLeft == 0) begin
               mMode = M_LOCKED;
            end
         end
         default: mMode = M_LOCKED;
      endcase
   endtask

   // Drive one cycle of inputs, step the model on the edge, compare all outputs after it
   task automatic applyStimulus(input logic d, input logic [3:0] dv, input logic ob, input logic lb, input logic sb);
      logic [5:0] expv;
      dirch    = d;
      dial     = dv;
      open_btn = ob;
      lock_btn = lb;
      set_btn  = sb;
      @(posedge clk);
      modelStep();
      #1;
      expv = {(mMode == M_OPEN) || (mMode == M_SET), mMode == M_LOCKOUT, mErr, mCnt, 2'(mIdx)};
      checkOutput("cycle", {unlocked, locked_out, err, cnt_rst, digits_entered}, expv);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic enterCode(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      applyStimulus(1'b1, a, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, b, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, c, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic waitLockoutEnd(input string tag);
      for (int i = 0; i < LOCKOUT + 100 && locked_out; i++) begin
         idle(1);
      end
      checkOutput(tag, locked_out, 1'b0);
   endtask

   initial begin
      int loCount;
      logic [3:0] dv;
      modelReset();
      rst = 1'b0;
      dirch = 1'b0;
      dial = 4'd0;
      open_btn = 1'b0;
      lock_btn = 1'b0;
      set_btn = 1'b0;
      idle(2);
      rst = 1'b1;
      checkOutput("reset_outputs", {unlocked, locked_out, err, cnt_rst, digits_entered}, 6'd0);

      // Correct default code opens two cycles after open_btn
      enterCode(4'd1, 4'd2, 4'd3);
      checkOutput("in_check_locked", unlocked, 1'b0);
      idle(1);
      checkOutput("open_123", unlocked, 1'b1);
      checkOutput("open_cnt_rst", cnt_rst, 1'b1);
      checkOutput("open_no_err", err, 1'b0);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      checkOutput("lock_beats_set", unlocked, 1'b0);

      // Three wrong entries lead to a lockout of exactly LOCKOUT cycles
      enterCode(4'd1, 4'd2, 4'd4);
      idle(1);
      checkOutput("fail1_err", err, 1'b1);
      enterCode(4'd1, 4'd2, 4'd4);
      idle(1);
      checkOutput("fail2_err", err, 1'b1);
      checkOutput("fail2_not_lockout", locked_out, 1'b0);
      enterCode(4'd1, 4'd2, 4'd4);
      idle(1);
      checkOutput("fail3_err", err, 1'b1);
      loCount = locked_out ? 1 : 0;
      applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
      if (locked_out) loCount++;
      applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
      if (locked_out) loCount++;
      applyStimulus(1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
      if (locked_out) loCount++;
      checkOutput("lockout_ignores_entry", unlocked, 1'b0);
      for (int i = 0; i < LOCKOUT + 100 && locked_out; i++) begin
         idle(1);
         if (locked_out) loCount++;
      end
      checkOutput("lockout_length", 16'(loCount), 16'd1000);
      enterCode(4'd1, 4'd2, 4'd3);
      idle(1);
      checkOutput("open_after_lockout", unlocked, 1'b1);

      // Re-program the code to 705
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      checkOutput("set_cnt_rst", cnt_rst, 1'b1);
      applyStimulus(1'b0, 4'd9, 1'b1, 1'b0, 1'b0);
      checkOutput("set_early_open_ignored", digits_entered, 2'd0);
      enterCode(4'd7, 4'd0, 4'd5);
      checkOutput("set_commit_open", unlocked, 1'b1);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("relock", unlocked, 1'b0);
      enterCode(4'd1, 4'd2, 4'd3);
      idle(1);
      checkOutput("old_code_err", err, 1'b1);
      enterCode(4'd7, 4'd0, 4'd5);
      idle(1);
      checkOutput("new_code_open", unlocked, 1'b1);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

      // Two fails, a timeout that does not count, then one more fail locks out
      enterCode(4'd1, 4'd2, 4'd4);
      idle(1);
      enterCode(4'd1, 4'd2, 4'd4);
      idle(1);
      applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
      checkOutput("timeout_digits_1", digits_entered, 2'd1);
      idle(TIMEOUT - 1);
      checkOutput("pre_timeout_digits", digits_entered, 2'd1);
      idle(1);
      checkOutput("timeout_digits_0", digits_entered, 2'd0);
      checkOutput("timeout_cnt_rst", cnt_rst, 1'b1);
      checkOutput("timeout_no_err", err, 1'b0);
      enterCode(4'd1, 4'd2, 4'd4);
      idle(1);
      checkOutput("timeout_third_fail_lockout", locked_out, 1'b1);
      waitLockoutEnd("lockout2_end");

      // Overrun fails; open_btn beats a simultaneous dirch
      applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
      idle(1);
      checkOutput("overrun_err", err, 1'b1);
      applyStimulus(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
      idle(1);
      checkOutput("open_beats_dirch", unlocked, 1'b1);

      // Reset in the middle of programming restores the default code
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
      checkOutput("set_idx1", digits_entered, 2'd1);
      rst = 1'b0;
      idle(1);
      rst = 1'b1;
      checkOutput("reset_mid_set_locked", unlocked, 1'b0);
      checkOutput("reset_mid_set_digits", digits_entered, 2'd0);
      enterCode(4'd1, 4'd2, 4'd3);
      idle(1);
      checkOutput("default_code_restored", unlocked, 1'b1);

      // Randomized traffic, with the dial biased toward the code the model believes is stored
      for (int i = 0; i < 4000; i++) begin
         logic d, ob, lb, sb;
         if ($urandom_range(9, 0) == 0) begin
            dv = 4'($urandom_range(15, 0));
         end else if ($urandom_range(1, 0) == 1 && mIdx <= 2) begin
            dv = 4'(mCode >> (4 * (2 - mIdx)));
         end else begin
            dv = 4'($urandom_range(9, 0));
         end
         d  = ($urandom_range(99, 0) < 30);
         ob = (mIdx == 2) ? ($urandom_range(99, 0) < 40) : ($urandom_range(99, 0) < 5);
         lb = ($urandom_range(99, 0) < 5);
         sb = ($urandom_range(99, 0) < 10);
         rst = ($urandom_range(399, 0) != 0);
         applyStimulus(d, dv, ob, lb, sb);
      end
      rst = 1'b1;

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule
